// File: rtl/eeprom_stream_reader_pkg.sv
// Shared definitions for the EEPROM stream reader: opcode, FSM encoding,
// header formatting and the byte-beat payload.
package eeprom_stream_reader_pkg;

  localparam logic [7:0]  EEPROM_READ_OP = 8'h03;
  localparam int unsigned HDR_WIDTH      = 24;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_ADDR = 3'd2,
    ST_READ = 3'd3,
    ST_HOLD = 3'd4,
    ST_FIN  = 3'd5
  } state_e;

  typedef struct packed {
    logic [7:0] index;
    logic [7:0] data;
  } stream_beat_t;

  // Opcode plus address, left-justified; an 8-bit address is padded with zeros.
  function automatic logic [HDR_WIDTH-1:0] header_word(input logic [15:0] addr,
                                                       input int unsigned addr_width);
    if (addr_width == 16) return {EEPROM_READ_OP, addr};
    return {EEPROM_READ_OP, addr[7:0], 8'h00};
  endfunction

endpackage

// File: rtl/eeprom_stream_reader_spi_bit_engine.sv
// SPI mode-0 bit engine: SCLK divider, bit counter, MOSI shift-out, MISO shift-in.
// sclk doubles as the phase flag (0 = low phase, 1 = high phase).
module spi_bit_engine #(
  parameter int unsigned SCLK_DIV = 1,
  parameter int unsigned TX_WIDTH = 24
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                load,
  input  logic                run,
  input  logic                clear,
  input  logic [TX_WIDTH-1:0] tx_word,
  input  logic                miso,
  output logic                sclk,
  output logic                mosi,
  output logic [7:0]          rx_byte,
  output logic                byte_end_c
);

  localparam int unsigned    DIV_W    = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);

  logic [DIV_W-1:0]    div_cnt;
  logic [2:0]          bit_cnt;
  logic [TX_WIDTH-1:0] tx_shift;

  assign byte_end_c = run && sclk && (div_cnt == DIV_LAST) && (bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_byte  <= '0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
    end else if (clear) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
    end else if (load) begin
      div_cnt  <= '0;
      bit_cnt  <= '0;
      sclk     <= 1'b0;
      mosi     <= tx_word[TX_WIDTH-1];
      tx_shift <= {tx_word[TX_WIDTH-2:0], 1'b0};
      rx_byte  <= '0;
    end else if (run) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        sclk    <= !sclk;
        if (!sclk) begin
          rx_byte <= {rx_byte[6:0], miso};
        end else begin
          // End of a high phase: next bit's data goes out with the new low phase.
          bit_cnt  <= bit_cnt + 3'd1;
          mosi     <= tx_shift[TX_WIDTH-1];
          tx_shift <= {tx_shift[TX_WIDTH-2:0], 1'b0};
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/eeprom_stream_reader.sv
// Burst reader for an SPI EEPROM: sends READ + address, then streams bytes out
// over valid/ready, freezing SCLK while a byte waits for the consumer.
module eeprom_stream_reader
  import eeprom_stream_reader_pkg::*;
#(
  parameter int unsigned NUM_BYTES  = 100,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned SCLK_DIV   = 1
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       start,
  input  logic       abort,
  input  logic       eeprom_out,
  output logic       eeprom_cs,
  output logic       eeprom_clk,
  output logic       eeprom_in,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic [7:0] byte_index,
  output logic       busy,
  output logic       done
);

  localparam int unsigned          ADDR_BYTES = ADDR_WIDTH / 8;
  localparam logic [7:0]           LAST_INDEX = 8'(NUM_BYTES - 1);
  localparam logic [HDR_WIDTH-1:0] HEADER     = header_word(16'(START_ADDR), ADDR_WIDTH);

  state_e       state, state_next;
  logic         addr_cnt, addr_cnt_next;
  stream_beat_t beat, beat_next;
  logic         cs_next, valid_next, busy_next, done_next;
  logic         xfer_c, last_xfer_c, freeze_c, abort_c, load_c, run_c, clear_c, byte_end_c;
  logic [7:0]   rx_byte;

  assign byte_out   = beat.data;
  assign byte_index = beat.index;

  assign xfer_c      = byte_valid && byte_ready;
  assign last_xfer_c = xfer_c && (beat.index == LAST_INDEX);
  assign freeze_c    = byte_valid && !byte_ready;
  assign abort_c     = abort && (state != ST_IDLE);
  assign load_c      = (state == ST_IDLE) && start && !abort;
  // The engine stops dead on the final transfer so no stray SCLK edge precedes CS rising.
  assign run_c       = (state inside {ST_CMD, ST_ADDR, ST_READ, ST_HOLD}) &&
                       !freeze_c && !abort_c && !last_xfer_c;
  assign clear_c     = abort_c || last_xfer_c;

  spi_bit_engine #(
    .SCLK_DIV (SCLK_DIV),
    .TX_WIDTH (HDR_WIDTH)
  ) u_engine (
    .clk        (clk),
    .nreset     (nreset),
    .load       (load_c),
    .run        (run_c),
    .clear      (clear_c),
    .tx_word    (HEADER),
    .miso       (eeprom_out),
    .sclk       (eeprom_clk),
    .mosi       (eeprom_in),
    .rx_byte    (rx_byte),
    .byte_end_c (byte_end_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= ST_IDLE;
      addr_cnt   <= 1'b0;
      beat       <= '0;
      eeprom_cs  <= 1'b1;
      byte_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      addr_cnt   <= addr_cnt_next;
      beat       <= beat_next;
      eeprom_cs  <= cs_next;
      byte_valid <= valid_next;
      busy       <= busy_next;
      done       <= done_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next    = state;
    addr_cnt_next = addr_cnt;
    unique case (state)
      ST_IDLE: if (load_c) begin
        state_next    = ST_CMD;
        addr_cnt_next = 1'b0;
      end
      ST_CMD:  if (byte_end_c) state_next = ST_ADDR;
      ST_ADDR: if (byte_end_c) begin
        if (addr_cnt == 1'(ADDR_BYTES - 1)) state_next = ST_READ;
        else                                addr_cnt_next = addr_cnt + 1'b1;
      end
      ST_READ: if (last_xfer_c)   state_next = ST_FIN;
               else if (freeze_c) state_next = ST_HOLD;
      ST_HOLD: if (last_xfer_c)   state_next = ST_FIN;
               else if (xfer_c)   state_next = ST_READ;
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (abort_c) state_next = ST_IDLE;
  end

  // Output next-values; later assignments take priority.
  always_comb begin
    beat_next  = beat;
    cs_next    = eeprom_cs;
    valid_next = byte_valid;
    busy_next  = busy;
    done_next  = 1'b0;
    if (xfer_c) begin
      valid_next      = 1'b0;
      beat_next.index = beat.index + 8'd1;
    end
    if ((state == ST_READ) && byte_end_c) begin
      valid_next     = 1'b1;
      beat_next.data = rx_byte;
    end
    if (load_c) begin
      cs_next         = 1'b0;
      busy_next       = 1'b1;
      beat_next.index = 8'd0;
    end
    if (state == ST_FIN) begin
      busy_next       = 1'b0;
      beat_next.index = 8'd0;
    end
    if (last_xfer_c) begin
      cs_next   = 1'b1;
      done_next = 1'b1;
    end
    if (abort_c) begin
      cs_next    = 1'b1;
      valid_next = 1'b0;
      busy_next  = 1'b0;
      done_next  = 1'b0;
    end
  end

endmodule

// File: tb/tb_eeprom_stream_reader.sv
// Bench: two reader instances (default and slow/8-bit-address) against a behavioural
// SPI EEPROM; per-burst monitor statistics checked against hand-computed tables.
module tb_eeprom_stream_reader;

  typedef struct {
    int         test;
    int         dut;
    int         idx;
    logic [7:0] data;
    int         rel;
  } vec_t;

  logic       clk = 1'b0;
  logic       nreset;
  logic       start [2];
  logic       abort [2];
  logic       ready [2];
  logic       miso  [2];
  logic       cs    [2];
  logic       sclk  [2];
  logic       mosi  [2];
  logic [7:0] bout  [2];
  logic       bvalid[2];
  logic [7:0] bidx  [2];
  logic       busy  [2];
  logic       done  [2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int e0[2], base[2], nbytes[2], data_err[2], stable_err[2], sclk_err[2], idx_err[2];
  int done_cnt[2], done_rel[2], hi_run[2], hi_len[2], ecnt[2];
  int arr_t[2][256];
  logic [7:0] arr_b[2][256];
  logic pv[2], pxfer[2], psclk[2], pcs[2];
  logic [7:0] pbout[2];
  logic [23:0] hdr[2];
  int cs_clk_err = 0;
  int stall_left = 0;
  int stall_idx = 0;
  logic stall_arm = 1'b0;
  vec_t tv[13];

  eeprom_stream_reader u_dut0 (
    .clk(clk), .nreset(nreset), .start(start[0]), .abort(abort[0]), .eeprom_out(miso[0]),
    .eeprom_cs(cs[0]), .eeprom_clk(sclk[0]), .eeprom_in(mosi[0]), .byte_out(bout[0]),
    .byte_valid(bvalid[0]), .byte_ready(ready[0]), .byte_index(bidx[0]), .busy(busy[0]),
    .done(done[0]));

  eeprom_stream_reader #(.NUM_BYTES(4), .ADDR_WIDTH(8), .START_ADDR('h40), .SCLK_DIV(3)) u_dut1 (
    .clk(clk), .nreset(nreset), .start(start[1]), .abort(abort[1]), .eeprom_out(miso[1]),
    .eeprom_cs(cs[1]), .eeprom_clk(sclk[1]), .eeprom_in(mosi[1]), .byte_out(bout[1]),
    .byte_valid(bvalid[1]), .byte_ready(ready[1]), .byte_index(bidx[1]), .busy(busy[1]),
    .done(done[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    logic [15:0] p;
    if (a == 16'd0) return 8'hA5;
    if (a == 16'd1) return 8'h3C;
    p = a * 16'd29;
    return p[7:0] ^ 8'h5A;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // EEPROM model: captures opcode/address on SCLK rise, presents data while SCLK is low.
  always @(negedge clk) begin : eeprom_model
    int hb, k;
    logic [15:0] a;
    logic [7:0] b;
    for (int d = 0; d < 2; d++) begin
      hb = (d == 0) ? 24 : 16;
      if (cs[d] && !pcs[d] && sclk[d]) cs_clk_err++;
      if (cs[d] !== 1'b0) begin
        ecnt[d] = 0;
        miso[d] = 1'b0;
      end else begin
        if (sclk[d] && !psclk[d]) begin
          if (ecnt[d] < hb) hdr[d] = {hdr[d][22:0], mosi[d]};
          ecnt[d]++;
        end
        if (!sclk[d]) begin
          if (ecnt[d] < hb) miso[d] = 1'b0;
          else begin
            k = ecnt[d] - hb;
            a = (d == 0) ? hdr[d][15:0] : {8'h00, hdr[d][7:0]};
            a = a + 16'(k / 8);
            b = mem_byte(a);
            miso[d] = b[7 - (k % 8)];
          end
        end
      end
      psclk[d] = sclk[d];
      pcs[d]   = cs[d];
    end
  end

  // Consumer stall injection on instance 0.
  always @(negedge clk) begin
    if (stall_left > 0) begin
      stall_left--;
      if (stall_left == 0) ready[0] = 1'b1;
    end else if (stall_arm && bvalid[0] && int'(bidx[0]) == stall_idx) begin
      ready[0]   = 1'b0;
      stall_left = 10;
      stall_arm  = 1'b0;
    end
  end

  // Stream monitor: arrival times relative to E0, data, stability and index order.
  always @(negedge clk) begin : monitor
    int rel;
    #2;
    for (int d = 0; d < 2; d++) begin
      rel = cyc - e0[d];
      if (bvalid[d] && !pv[d]) begin
        arr_t[d][bidx[d]] = rel;
        arr_b[d][bidx[d]] = bout[d];
        if (bout[d] !== mem_byte(16'(base[d] + int'(bidx[d])))) data_err[d]++;
      end
      if (bvalid[d] && pv[d] && !pxfer[d] && bout[d] !== pbout[d]) stable_err[d]++;
      if (bvalid[d] && sclk[d]) sclk_err[d]++;
      if (bvalid[d] && ready[d]) begin
        if (int'(bidx[d]) != nbytes[d]) idx_err[d]++;
        nbytes[d]++;
      end
      if (done[d]) begin
        done_cnt[d]++;
        done_rel[d] = rel;
      end
      if (sclk[d]) hi_run[d]++;
      else if (hi_run[d] > 0) begin
        hi_len[d] = hi_run[d];
        hi_run[d] = 0;
      end
      pv[d]    = bvalid[d];
      pbout[d] = bout[d];
      pxfer[d] = bvalid[d] && ready[d];
    end
  end

  task automatic start_burst(input int d);
    nbytes[d] = 0; data_err[d] = 0; stable_err[d] = 0; sclk_err[d] = 0;
    idx_err[d] = 0; done_cnt[d] = 0; done_rel[d] = -1;
    for (int i = 0; i < 256; i++) arr_t[d][i] = -1;
    @(negedge clk);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    e0[d] = cyc;
  endtask

  task automatic run_burst(input int d, input int restart_at);
    start_burst(d);
    for (int n = 0; n < 4000; n++) begin
      if (!busy[d]) break;
      @(negedge clk);
      start[d] = (restart_at > 0 && cyc - e0[d] == restart_at);
    end
    start[d] = 1'b0;
    check("burst_terminates", int'(busy[d]), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic apply_table(input int t);
    for (int i = 0; i < 13; i++) begin
      if (tv[i].test == t) begin
        check($sformatf("t%0d_byte%0d_data", t, tv[i].idx), int'(arr_b[tv[i].dut][tv[i].idx]),
              int'(tv[i].data));
        check($sformatf("t%0d_byte%0d_time", t, tv[i].idx), arr_t[tv[i].dut][tv[i].idx], tv[i].rel);
      end
    end
  endtask

  task automatic check_reset(input string name, input int d);
    check({name, "_ctl"}, int'({cs[d], sclk[d], mosi[d], bvalid[d], busy[d], done[d]}), 'b100000);
    check({name, "_data"}, int'({bout[d], bidx[d]}), 0);
  endtask

  initial begin
    tv[0]  = '{1, 0, 0,  8'hA5, 64};
    tv[1]  = '{1, 0, 1,  8'h3C, 80};
    tv[2]  = '{1, 0, 5,  8'hCB, 144};
    tv[3]  = '{1, 0, 6,  8'hF4, 160};
    tv[4]  = '{1, 0, 99, 8'h6D, 1648};
    tv[5]  = '{2, 0, 5,  8'hCB, 144};
    tv[6]  = '{2, 0, 6,  8'hF4, 170};
    tv[7]  = '{2, 0, 7,  8'h91, 186};
    tv[8]  = '{2, 0, 99, 8'h6D, 1658};
    tv[9]  = '{3, 1, 0,  8'h1A, 144};
    tv[10] = '{3, 1, 1,  8'h07, 192};
    tv[11] = '{3, 1, 2,  8'h20, 240};
    tv[12] = '{3, 1, 3,  8'hCD, 288};
    base[0] = 0; base[1] = 'h40;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; abort[d] = 1'b0; ready[d] = 1'b1; e0[d] = 0;
      pv[d] = 1'b0; pxfer[d] = 1'b0; psclk[d] = 1'b0; pcs[d] = 1'b1; pbout[d] = '0;
      hdr[d] = '0; hi_run[d] = 0; hi_len[d] = 0; ecnt[d] = 0;
    end
    nreset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset_d0", 0);
    check_reset("reset_d1", 1);
    nreset = 1'b1;

    // 1: default burst
    run_burst(0, 0);
    check("t1_header", int'(hdr[0]), 'h030000);
    check("t1_count", nbytes[0], 100);
    check("t1_data_all", data_err[0], 0);
    check("t1_index_order", idx_err[0], 0);
    check("t1_done_pulses", done_cnt[0], 1);
    check("t1_done_time", done_rel[0], 1649);
    check("t1_cs_high", int'(cs[0]), 1);
    check("t1_sclk_half", hi_len[0], 1);
    apply_table(1);

    // 2: consumer stall on byte 5
    stall_idx = 5; stall_arm = 1'b1;
    run_burst(0, 0);
    check("t2_count", nbytes[0], 100);
    check("t2_data_all", data_err[0], 0);
    check("t2_byte_stable", stable_err[0], 0);
    check("t2_sclk_frozen", sclk_err[0], 0);
    check("t2_done_time", done_rel[0], 1659);
    apply_table(2);

    // 3: slow clock, 8-bit address at 0x40
    run_burst(1, 0);
    check("t3_header", int'(hdr[1][15:0]), 'h0340);
    check("t3_sclk_half", hi_len[1], 3);
    check("t3_count", nbytes[1], 4);
    check("t3_data_all", data_err[1], 0);
    check("t3_done_time", done_rel[1], 289);
    apply_table(3);

    // 4: abort in address phase, then a clean burst
    start_burst(0);
    repeat (20) @(negedge clk);
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    check("t4_abort_cs", int'(cs[0]), 1);
    check("t4_abort_busy", int'(busy[0]), 0);
    check("t4_abort_sclk", int'(sclk[0]), 0);
    repeat (5) @(negedge clk);
    check("t4_no_done", done_cnt[0], 0);
    run_burst(0, 0);
    check("t4_rerun_count", nbytes[0], 100);
    check("t4_rerun_data", data_err[0], 0);
    check("t4_rerun_done", done_rel[0], 1649);

    // 5: asynchronous reset mid-read
    start_burst(0);
    repeat (300) @(negedge clk);
    nreset = 1'b0;
    #1;
    check_reset("t5_async_reset", 0);
    @(negedge clk);
    nreset = 1'b1;
    run_burst(0, 0);
    check("t5_first_time", arr_t[0][0], 64);
    check("t5_count", nbytes[0], 100);
    check("t5_index_order", idx_err[0], 0);
    check("t5_data_all", data_err[0], 0);

    // 6: start+abort in idle, then start while busy
    @(negedge clk);
    start[0] = 1'b1; abort[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0; abort[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_idle_busy", int'(busy[0]), 0);
    check("t6_idle_cs", int'(cs[0]), 1);
    run_burst(0, 500);
    check("t6_done_time", done_rel[0], 1649);
    check("t6_count", nbytes[0], 100);
    check("t6_done_pulses", done_cnt[0], 1);
    check("t6_data_all", data_err[0], 0);

    check("cs_rise_with_sclk_high", cs_clk_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
